fwd_hazard_unit: RTL and testbench

- Parametrised successor to the two-operand forwarding logic.
- Computes forwarding selects for NUM_SRC source operands, registers them across the ID/EXE boundary, and resolves branch operands in ID.
- Detects load-use and branch-dependency hazards and drives a counted stall FSM, with configurable load latency.
- Sits between the ID stage, the ID/EXE pipeline register and the hazard/PC control.

---
 rtl/fwd_pkg.sv | 24 ++
 rtl/fwd_src_match.sv | 36 +++
 rtl/fwd_hazard_unit.sv | 92 +++++++++
 tb/tb_fwd_hazard_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// fwd_pkg: select encodings, stall FSM states and the per-operand stall-length rule
package fwd_pkg;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic {RUN, HOLD} fsm_state_t;

    function automatic int unsigned stallCycles(
        input logic exMatch,
        input logic exLoad,
        input logic memMatch,
        input logic memLoad,
        input logic isBranch,
        input int unsigned loadLatency
    );
        if (exMatch && exLoad) return loadLatency + 32'(isBranch);
        if (exMatch && isBranch) return 1;
        if (memMatch && memLoad && isBranch) return 1;
        return 0;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// fwd_src_match: per-operand producer match, EXE/branch forwarding selects and required stall
module fwd_src_match import fwd_pkg::*; #(
    parameter int AW = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W = 3
) (
    input  logic             idValid,
    input  logic [AW-1:0]    src,
    input  logic             srcUsed,
    input  logic             isBranch,
    input  logic [AW-1:0]    exRd,
    input  logic             exWe,
    input  logic             exIsLoad,
    input  logic [AW-1:0]    memRd,
    input  logic             memWe,
    input  logic             memIsLoad,
    output logic [1:0]       exeSel,
    output logic [1:0]       brSel,
    output logic [CNT_W-1:0] stallReq
);

    logic reads;
    logic exMatch;
    logic memMatch;

    assign reads    = idValid && srcUsed && (src != '0);
    assign exMatch  = reads && exWe && (src == exRd);
    assign memMatch = reads && memWe && (src == memRd);

    assign exeSel = exMatch ? FWD_EXMEM : memMatch ? FWD_MEMWB : FWD_RF;
    // a MEM load cannot be bypassed into an ID compare; the stall covers it
    assign brSel  = (isBranch && memMatch && !memIsLoad) ? FWD_EXMEM : FWD_RF;

    assign stallReq = CNT_W'(stallCycles(exMatch, exIsLoad, memMatch, memIsLoad, isBranch, LOAD_LATENCY));

endmodule

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: N-operand forwarding selects, ID branch bypass and counted load/branch stall FSM
module fwd_hazard_unit import fwd_pkg::*; #(
    parameter int NUM_SRC = 2,
    parameter int AW = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W = 3
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic                  STALL,
    input  logic                  FLUSH,
    input  logic                  ID_VALID_IN,
    input  logic [NUM_SRC*AW-1:0] ID_SRC_IN,
    input  logic [NUM_SRC-1:0]    ID_SRC_USED_IN,
    input  logic                  ID_IS_BRANCH_IN,
    input  logic [AW-1:0]         EX_RD_IN,
    input  logic                  EX_WE_IN,
    input  logic                  EX_IS_LOAD_IN,
    input  logic [AW-1:0]         MEM_RD_IN,
    input  logic                  MEM_WE_IN,
    input  logic                  MEM_IS_LOAD_IN,
    output logic [2*NUM_SRC-1:0]  FWD_SEL_OUT,
    output logic [2*NUM_SRC-1:0]  BR_FWD_SEL_OUT,
    output logic                  HAZARD_STALL_OUT,
    output logic [CNT_W-1:0]      STALL_CNT_OUT
);

    localparam logic [CNT_W-1:0] cntOne = CNT_W'(1);

    fsm_state_t state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt, need;
    logic [CNT_W-1:0] slotStall [NUM_SRC];
    logic [2*NUM_SRC-1:0] exeSel;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSlot
        fwd_src_match #(.AW(AW), .LOAD_LATENCY(LOAD_LATENCY), .CNT_W(CNT_W)) uMatch (
            .idValid  (ID_VALID_IN),
            .src      (ID_SRC_IN[i*AW +: AW]),
            .srcUsed  (ID_SRC_USED_IN[i]),
            .isBranch (ID_IS_BRANCH_IN),
            .exRd     (EX_RD_IN),
            .exWe     (EX_WE_IN),
            .exIsLoad (EX_IS_LOAD_IN),
            .memRd    (MEM_RD_IN),
            .memWe    (MEM_WE_IN),
            .memIsLoad(MEM_IS_LOAD_IN),
            .exeSel   (exeSel[2*i +: 2]),
            .brSel    (BR_FWD_SEL_OUT[2*i +: 2]),
            .stallReq (slotStall[i])
        );
    end

    always_comb begin
        need = '0;
        for (int i = 0; i < NUM_SRC; i++)
            need = (slotStall[i] > need) ? slotStall[i] : need;
    end

    // outputs read as idle while reset is held, regardless of hazard inputs
    assign HAZARD_STALL_OUT = RESET && !FLUSH && ((state == HOLD) || (need != '0));
    assign STALL_CNT_OUT = !RESET ? '0 : (state == HOLD) ? cnt : (need > cntOne) ? need - cntOne : '0;

    always_comb begin
        nextState = state;
        nextCnt = cnt;
        if (FLUSH) begin
            nextState = RUN;
            nextCnt = '0;
        end else if (!STALL) begin
            if (state == HOLD) begin
                nextCnt = cnt - cntOne;
                nextState = (cnt == cntOne) ? RUN : HOLD;
            end else if (need > cntOne) begin
                nextState = HOLD;
                nextCnt = need - cntOne;
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= RUN;
            cnt <= '0;
            FWD_SEL_OUT <= '0;
        end else begin
            state <= nextState;
            cnt <= nextCnt;
            FWD_SEL_OUT <= FLUSH ? '0 : STALL ? FWD_SEL_OUT : HAZARD_STALL_OUT ? '0 : exeSel;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed checks of forwarding, branch bypass and stall FSM at load latencies 1 and 2
module tb_fwd_hazard_unit;

    logic clock = 1'b0;
    logic reset, stall, flush;
    logic idValid, idBranch;
    logic [9:0] idSrc;
    logic [1:0] idUsed;
    logic [4:0] exRd, memRd;
    logic exWe, exLoad, memWe, memLoad;
    logic [3:0] fwd1, br1, fwd2, br2;
    logic hs1, hs2;
    logic [2:0] cnt1, cnt2;

    int checks = 0;
    int failures = 0;

    typedef struct {
        string tag;
        logic [3:0] exp;
    } sbEntry;
    sbEntry sbq[$];

    always #5 clock = ~clock;

    fwd_hazard_unit #(.LOAD_LATENCY(1)) dut1 (
        .CLOCK(clock), .RESET(reset), .STALL(stall), .FLUSH(flush),
        .ID_VALID_IN(idValid), .ID_SRC_IN(idSrc), .ID_SRC_USED_IN(idUsed), .ID_IS_BRANCH_IN(idBranch),
        .EX_RD_IN(exRd), .EX_WE_IN(exWe), .EX_IS_LOAD_IN(exLoad),
        .MEM_RD_IN(memRd), .MEM_WE_IN(memWe), .MEM_IS_LOAD_IN(memLoad),
        .FWD_SEL_OUT(fwd1), .BR_FWD_SEL_OUT(br1), .HAZARD_STALL_OUT(hs1), .STALL_CNT_OUT(cnt1)
    );

    fwd_hazard_unit #(.LOAD_LATENCY(2)) dut2 (
        .CLOCK(clock), .RESET(reset), .STALL(stall), .FLUSH(flush),
        .ID_VALID_IN(idValid), .ID_SRC_IN(idSrc), .ID_SRC_USED_IN(idUsed), .ID_IS_BRANCH_IN(idBranch),
        .EX_RD_IN(exRd), .EX_WE_IN(exWe), .EX_IS_LOAD_IN(exLoad),
        .MEM_RD_IN(memRd), .MEM_WE_IN(memWe), .MEM_IS_LOAD_IN(memLoad),
        .FWD_SEL_OUT(fwd2), .BR_FWD_SEL_OUT(br2), .HAZARD_STALL_OUT(hs2), .STALL_CNT_OUT(cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic v, input logic [4:0] s1, input logic [4:0] s0, input logic [1:0] u,
                         input logic br, input logic [4:0] er, input logic ew, input logic el,
                         input logic [4:0] mr, input logic mw, input logic ml);
        idValid = v; idSrc = {s1, s0}; idUsed = u; idBranch = br;
        exRd = er; exWe = ew; exLoad = el;
        memRd = mr; memWe = mw; memLoad = ml;
    endtask

    task automatic push(input string tag, input logic [3:0] exp);
        sbq.push_back('{tag, exp});
    endtask

    task automatic tick();
        sbEntry e;
        @(posedge clock);
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            check(e.tag, 32'(fwd1), 32'(e.exp));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0;
        setIn(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check("rstFwd1", 32'(fwd1), 0);
        check("rstHs1", 32'(hs1), 0);
        check("rstCnt1", 32'(cnt1), 0);
        check("rstFwd2", 32'(fwd2), 0);
        #10 reset = 1'b1;

        // forwarding from EXE, MEM, and EXE priority
        setIn(1, 0, 3, 2'b01, 0, 3, 1, 0, 0, 0, 0); #1;
        check("exHs", 32'(hs1), 0);
        push("exSel", 4'b0010); tick();
        setIn(1, 0, 3, 2'b01, 0, 0, 0, 0, 3, 1, 0); push("memSel", 4'b0001); tick();
        setIn(1, 0, 3, 2'b01, 0, 3, 1, 0, 3, 1, 0); push("exPrio", 4'b0010); tick();
        setIn(1, 3, 3, 2'b11, 0, 3, 1, 0, 0, 0, 0); push("bothSlots", 4'b1010); tick();

        // load-use at latency 2: two stall cycles, bubble captured
        setIn(1, 8, 0, 2'b10, 0, 8, 1, 1, 0, 0, 0); #1;
        check("luHs2a", 32'(hs2), 1);
        check("luCnt2a", 32'(cnt2), 1);
        check("luHs1", 32'(hs1), 1);
        check("luCnt1", 32'(cnt1), 0);
        push("luBubble", 4'b0000); tick();
        check("luHs2b", 32'(hs2), 1);
        check("luCnt2b", 32'(cnt2), 1);
        check("luFwd2b", 32'(fwd2), 0);
        setIn(1, 8, 0, 2'b10, 0, 0, 0, 0, 0, 0, 0); #1;
        check("luHs2c", 32'(hs2), 1);
        check("luHs1c", 32'(hs1), 0);
        push("luAfter1", 4'b0000); tick();
        check("luHs2d", 32'(hs2), 0);
        check("luCnt2d", 32'(cnt2), 0);
        check("luFwd2d", 32'(fwd2), 0);

        // branch after load at latency 1, then branch bypass from MEM
        setIn(1, 0, 5, 2'b01, 1, 5, 1, 1, 0, 0, 0); #1;
        check("blHs", 32'(hs1), 1);
        check("blCnt", 32'(cnt1), 1);
        check("blBr", 32'(br1), 0);
        push("blBubble", 4'b0000); tick();
        check("blHoldHs", 32'(hs1), 1);
        check("blHoldCnt", 32'(cnt1), 1);
        setIn(1, 0, 5, 2'b01, 1, 0, 0, 0, 0, 0, 0); #1;
        check("blHold2", 32'(hs1), 1);
        push("blBubble2", 4'b0000); tick();
        check("blRunHs", 32'(hs1), 0);
        setIn(1, 0, 5, 2'b01, 1, 0, 0, 0, 5, 1, 0); #1;
        check("brMem", 32'(br1), 4'b0010);
        check("brMemHs", 32'(hs1), 0);
        push("brMemSel", 4'b0001); tick();
        setIn(1, 0, 5, 2'b01, 1, 0, 0, 0, 5, 1, 1); #1;
        check("brLdBr", 32'(br1), 0);
        check("brLdHs", 32'(hs1), 1);
        push("brLdBubble", 4'b0000); tick();
        setIn(1, 0, 5, 2'b01, 1, 5, 1, 0, 0, 0, 0); #1;
        check("brExHs", 32'(hs1), 1);
        check("brExCnt", 32'(cnt1), 0);
        check("brExBr", 32'(br1), 0);
        push("brExBubble", 4'b0000); tick();

        // register 0, unused slots, invalid instruction
        setIn(1, 0, 0, 2'b11, 0, 0, 1, 1, 0, 1, 0); #1;
        check("r0Hs1", 32'(hs1), 0);
        check("r0Hs2", 32'(hs2), 0);
        push("r0Sel", 4'b0000); tick();
        setIn(1, 8, 8, 2'b00, 1, 8, 1, 1, 8, 1, 0); #1;
        check("unusedHs", 32'(hs1), 0);
        check("unusedBr", 32'(br1), 0);
        push("unusedSel", 4'b0000); tick();
        setIn(0, 8, 8, 2'b11, 1, 8, 1, 1, 8, 1, 0); #1;
        check("invHs", 32'(hs1), 0);
        check("invBr", 32'(br1), 0);
        push("invSel", 4'b0000); tick();

        // STALL holds the select register, FLUSH clears it even under STALL
        setIn(1, 0, 3, 2'b01, 0, 3, 1, 0, 0, 0, 0); push("preStall", 4'b0010); tick();
        stall = 1'b1;
        setIn(1, 0, 3, 2'b01, 0, 0, 0, 0, 3, 1, 0); push("stallHold", 4'b0010); tick();
        flush = 1'b1; push("flushClr", 4'b0000); tick();
        flush = 1'b0; stall = 1'b0;

        // STALL freezes HOLD; FLUSH with STALL returns to RUN
        setIn(1, 8, 0, 2'b10, 0, 8, 1, 1, 0, 0, 0); #1;
        check("h2Hs", 32'(hs2), 1);
        tick();
        stall = 1'b1;
        setIn(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("stHoldCnt", 32'(cnt2), 1);
        check("stHoldHs", 32'(hs2), 1);
        flush = 1'b1; #1;
        check("flHs2", 32'(hs2), 0);
        tick();
        flush = 1'b0; stall = 1'b0; #1;
        check("flHs2b", 32'(hs2), 0);
        check("flCnt2", 32'(cnt2), 0);
        check("flFwd2", 32'(fwd2), 0);

        // asynchronous reset pulse between edges while in HOLD
        setIn(1, 8, 0, 2'b10, 0, 8, 1, 1, 0, 0, 0);
        tick();
        #3 reset = 1'b0;
        #1;
        check("arHs2", 32'(hs2), 0);
        check("arCnt2", 32'(cnt2), 0);
        check("arFwd2", 32'(fwd2), 0);
        setIn(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        #1 reset = 1'b1;
        #1;
        check("arRunHs2", 32'(hs2), 0);
        setIn(1, 0, 3, 2'b01, 0, 3, 1, 0, 0, 0, 0);
        push("postRst", 4'b0010); tick();
        check("postRst2", 32'(fwd2), 4'b0010);

        check("sbDrained", 32'(sbq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
